// File: rtl/pattern_unpacker.sv
// Streams the mask-selected elements of one packed word out one beat at a time,
// lowest pattern position (MSB slice) first.
module pattern_unpacker #(
  parameter  int ELEM_W = 32,
  parameter  int N_ELEM = 4,
  localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_ELEM*ELEM_W-1:0]   in_word,
  input  logic [N_ELEM-1:0]          in_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEM_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic [15:0]                words_done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                     state_q;
  logic [N_ELEM*ELEM_W-1:0]   word_q;
  logic [N_ELEM-1:0]          mask_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic [ELEM_W-1:0]          out_data_q;
  logic [IDX_W-1:0]           out_idx_q;
  logic                       out_last_q;
  logic [15:0]                words_done_q;

  logic [IDX_W-1:0]           first_idx_d;
  logic                       first_last_d;
  logic [ELEM_W-1:0]          first_data_d;
  logic [IDX_W-1:0]           adv_idx_d;
  logic                       adv_last_d;
  logic [ELEM_W-1:0]          adv_data_d;

  // Lowest set position at or above start; callers guarantee one exists.
  function automatic logic [IDX_W-1:0] find_from(input logic [N_ELEM-1:0] m, input int start);
    logic [IDX_W-1:0] p;
    p = '0;
    for (int i = N_ELEM - 1; i >= 0; i--) begin
      if (i >= start && m[i]) p = IDX_W'(i);
    end
    return p;
  endfunction

  function automatic logic none_above(input logic [N_ELEM-1:0] m, input int pos);
    logic r;
    r = 1'b1;
    for (int i = 0; i < N_ELEM; i++) begin
      if (i > pos && m[i]) r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [ELEM_W-1:0] slice_at(input logic [N_ELEM*ELEM_W-1:0] w, input int p);
    logic [ELEM_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (i == p) r = w[(N_ELEM-1-i)*ELEM_W +: ELEM_W];
    end
    return r;
  endfunction

  always_comb begin
    first_idx_d  = find_from(in_mask, 0);
    first_last_d = none_above(in_mask, int'(first_idx_d));
    first_data_d = slice_at(in_word, int'(first_idx_d));
    adv_idx_d    = find_from(mask_q, int'(out_idx_q) + 1);
    adv_last_d   = none_above(mask_q, int'(adv_idx_d));
    adv_data_d   = slice_at(word_q, int'(adv_idx_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      mask_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      words_done_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            word_q <= in_word;
            mask_q <= in_mask;
            if (|in_mask) begin
              state_q     <= EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= first_data_d;
              out_idx_q   <= first_idx_d;
              out_last_q  <= first_last_d;
            end else begin
              // An empty selection still counts as a consumed word.
              words_done_q <= words_done_q + 16'd1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q      <= IDLE;
              in_ready_q   <= 1'b1;
              out_valid_q  <= 1'b0;
              words_done_q <= words_done_q + 16'd1;
            end else begin
              out_data_q <= adv_data_d;
              out_idx_q  <= adv_idx_d;
              out_last_q <= adv_last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_pattern_unpacker.sv
// Directed bench for pattern_unpacker: a 3-element and a 4-element instance,
// each with a scoreboard queue of expected beats.
module tb_pattern_unpacker;

  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          last;
  } beat_t;

  logic clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [95:0] a_in_word;
  logic [2:0]  a_in_mask;
  logic [31:0] a_out_data;
  logic [1:0]  a_out_idx;
  logic [15:0] a_words_done;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [127:0] b_in_word;
  logic [3:0]   b_in_mask;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_idx;
  logic [15:0]  b_words_done;

  beat_t qa[$];
  beat_t qb[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_wd_a = 0;
  int    exp_wd_b = 0;

  localparam logic [31:0] EA = 32'hA0A0_0001;
  localparam logic [31:0] EB = 32'hB0B0_0002;
  localparam logic [31:0] EC = 32'hC0C0_0003;
  localparam logic [31:0] ED = 32'hD0D0_0004;

  pattern_unpacker #(.ELEM_W(32), .N_ELEM(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_word(a_in_word), .in_mask(a_in_mask),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_idx(a_out_idx), .out_last(a_out_last),
    .words_done(a_words_done)
  );

  pattern_unpacker #(.ELEM_W(32), .N_ELEM(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_word(b_in_word), .in_mask(b_in_mask),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last),
    .words_done(b_words_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=completion", tag);
  endtask

  // Scoreboard consumers: a beat is taken at the posedge following this negedge.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL a_extra_beat observed=idx%0d expected=none", a_out_idx);
      end else begin
        e = qa.pop_front();
        check("a_data", a_out_data, e.data);
        check("a_idx", a_out_idx, e.idx);
        check("a_last", a_out_last, e.last);
        if (e.last) exp_wd_a++;
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL b_extra_beat observed=idx%0d expected=none", b_out_idx);
      end else begin
        e = qb.pop_front();
        check("b_data", b_out_data, e.data);
        check("b_idx", b_out_idx, e.idx);
        check("b_last", b_out_last, e.last);
        if (e.last) exp_wd_b++;
      end
    end
  end

  task automatic send_a(input logic [95:0] w, input logic [2:0] m);
    int n;
    bit hs;
    beat_t e;
    a_in_word  = w;
    a_in_mask  = m;
    a_in_valid = 1'b1;
    for (int p = 0; p < 3; p++) begin
      if (m[p]) begin
        e.data = w[(2-p)*32 +: 32];
        e.idx  = p;
        e.last = ((m >> (p + 1)) == 3'b000);
        qa.push_back(e);
      end
    end
    n = 0;
    do begin
      hs = a_in_ready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 100);
    a_in_valid = 1'b0;
    if (!hs) timeout_fail("a_accept");
    check("a_first_valid", a_out_valid, (m != 3'b000));
    check("a_post_ready", a_in_ready, (m == 3'b000));
    if (m == 3'b000) begin
      exp_wd_a++;
      check("a_wd_zero_mask", a_words_done, exp_wd_a);
    end
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while ((qa.size() != 0 || !a_in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) timeout_fail("a_drain");
  endtask

  task automatic drain_b();
    int n;
    n = 0;
    while ((qb.size() != 0 || !b_in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) timeout_fail("b_drain");
  endtask

  initial begin
    int  n;
    bit  hs;
    beat_t e;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_word = '0; a_in_mask = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_word = '0; b_in_mask = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_idx", a_out_idx, 0);
    check("rst_out_last", a_out_last, 0);
    check("rst_words_done", a_words_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All three positions, no backpressure.
    send_a({32'd1, 32'd2, 32'd3}, 3'b111);
    check("t1_first_idx", a_out_idx, 0);
    check("t1_first_data", a_out_data, 1);
    drain_a();
    check("t1_words_done", a_words_done, exp_wd_a);
    check("t1_words_done_1", a_words_done, 1);

    // Empty mask: nothing emitted, count bumps straight away.
    send_a({32'd7, 32'd8, 32'd9}, 3'b000);
    repeat (3) begin
      @(posedge clk); #1;
      check("t3_no_valid", a_out_valid, 0);
      check("t3_ready_high", a_in_ready, 1);
    end
    check("t3_words_done_2", a_words_done, 2);

    // Backpressure held on the idx1 beat.
    send_a({32'd1, 32'd2, 32'd3}, 3'b111);
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check("t4_idx1_shown", a_out_idx, 1);
    repeat (5) begin
      @(posedge clk); #1;
      check("t4_hold_valid", a_out_valid, 1);
      check("t4_hold_data", a_out_data, 2);
      check("t4_hold_idx", a_out_idx, 1);
      check("t4_hold_last", a_out_last, 0);
    end
    a_out_ready = 1'b1;
    drain_a();
    check("t4_words_done_3", a_words_done, 3);

    // Sparse mask on the 4-element instance, next word offered during EMIT.
    b_in_word  = {EA, EB, EC, ED};
    b_in_mask  = 4'b1010;
    b_in_valid = 1'b1;
    e.data = EB; e.idx = 1; e.last = 1'b0; qb.push_back(e);
    e.data = ED; e.idx = 3; e.last = 1'b1; qb.push_back(e);
    @(posedge clk); #1;
    check("t2_first_valid", b_out_valid, 1);
    check("t2_first_idx", b_out_idx, 1);
    check("t2_first_data", b_out_data, EB);
    check("t2_ready_low", b_in_ready, 0);
    b_in_word = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    b_in_mask = 4'b0001;
    e.data = 32'h1111_2222; e.idx = 0; e.last = 1'b1; qb.push_back(e);
    n = 0;
    do begin
      hs = b_in_ready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 100);
    b_in_valid = 1'b0;
    if (!hs) timeout_fail("b_accept");
    check("t2_single_valid", b_out_valid, 1);
    check("t2_single_idx", b_out_idx, 0);
    check("t2_single_last", b_out_last, 1);
    drain_b();
    check("t2_words_done", b_words_done, exp_wd_b);
    check("t2_words_done_2", b_words_done, 2);

    // Reset asserted while the idx1 beat is presented.
    send_a({32'd1, 32'd2, 32'd3}, 3'b111);
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check("t5_idx1_shown", a_out_idx, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid_drop", a_out_valid, 0);
    check("t5_ready_rst", a_in_ready, 1);
    check("t5_wd_rst", a_words_done, 0);
    qa.delete();
    qb.delete();
    exp_wd_a = 0;
    exp_wd_b = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_ready_after", a_in_ready, 1);
    check("t5_valid_after", a_out_valid, 0);
    check("t5_wd_after", a_words_done, 0);

    // Count wrap via back-to-back empty-mask words.
    a_in_mask  = 3'b000;
    a_in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("t6_wd_ffff", a_words_done, 16'hFFFF);
    check("t6_ready", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check("t6_wd_wrap", a_words_done, 16'h0000);
    check("t6_no_valid", a_out_valid, 0);

    check("end_qa_empty", qa.size(), 0);
    check("end_qb_empty", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
